// File: rtl/btb_update_ctrl.sv
// Write-side controller for the direct-mapped BTB: queues resolved-branch updates from two execute
// ports, drains one per cycle, and walks the table clearing it after reset/flush. Option: BTB_UPD_COALESCE_EN.
module btb_update_ctrl #(
  parameter int BTB_ADDRESS = 6,
  parameter int XLEN        = 32,
  parameter int TAG_SIZE    = XLEN - BTB_ADDRESS - 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               CLK,
  input  logic                               reset,
  input  logic                               req0_valid,
  input  logic [XLEN-1:0]                    req0_pc,
  input  logic [XLEN-1:0]                    req0_target,
  input  logic                               req0_is_ret,
  input  logic                               req0_is_branch,
  input  logic                               req1_valid,
  input  logic [XLEN-1:0]                    req1_pc,
  input  logic [XLEN-1:0]                    req1_target,
  input  logic                               req1_is_ret,
  input  logic                               req1_is_branch,
  output logic                               in_ready,
  input  logic                               flush_req,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending_count,
  output logic                               btb_wr_en,
  output logic [BTB_ADDRESS-1:0]             btb_wr_index,
  output logic [TAG_SIZE-1:0]                btb_wr_tag,
  output logic [XLEN-1:0]                    btb_wr_target,
  output logic                               btb_wr_valid,
  output logic                               btb_wr_is_ret,
  output logic                               btb_wr_is_branch,
  output logic [1:0]                         dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                 state_q;
  logic [BTB_ADDRESS-1:0] widx_q;
  logic [PW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]          count_q;
  // Only the word-aligned part of the PC is kept; bits [1:0] never reach the table.
  logic [XLEN-3:0]        pcw_q [FIFO_DEPTH];
  logic [XLEN-1:0]        tgt_q [FIFO_DEPTH];
  logic                   ret_q [FIFO_DEPTH];
  logic                   br_q  [FIFO_DEPTH];

  logic            running, walking, pop, acc0, acc1, new0, new1;
  logic [PW-1:0]   slot0, slot1;
  logic [CW-1:0]   free_slots, push_cnt;
  logic [XLEN-3:0] head_pcw, req0_pcw, req1_pcw;
  logic            unused_pc_bits;

  assign req0_pcw       = req0_pc[XLEN-1:2];
  assign req1_pcw       = req1_pc[XLEN-1:2];
  assign unused_pc_bits = ^{req0_pc[1:0], req1_pc[1:0]};

  // Valid/ready: a request slot transfers on a rising edge where reqX_valid && in_ready; in_ready
  // only rises when both slots fit, so both ports are always accepted or refused together.
  assign running    = reset && (state_q == RUN);
  assign walking    = reset && (state_q != RUN);
  assign free_slots = CW'(FIFO_DEPTH) - count_q;
  assign in_ready   = running && !flush_req && (free_slots >= CW'(2));
  assign busy       = !reset || (state_q != RUN);
  assign pop        = running && (count_q != '0);
  assign acc0       = req0_valid && in_ready;
  assign acc1       = req1_valid && in_ready;
  assign head_pcw   = pcw_q[rd_ptr_q];
  assign pending_count = reset ? count_q : '0;
  assign dbg_state  = state_q;

  always_comb begin
    btb_wr_en        = 1'b0;
    btb_wr_index     = '0;
    btb_wr_tag       = '0;
    btb_wr_target    = '0;
    btb_wr_valid     = 1'b0;
    btb_wr_is_ret    = 1'b0;
    btb_wr_is_branch = 1'b0;
    if (walking) begin
      btb_wr_en    = 1'b1;
      btb_wr_index = widx_q;
    end else if (pop) begin
      btb_wr_en        = 1'b1;
      btb_wr_index     = head_pcw[BTB_ADDRESS-1:0];
      btb_wr_tag       = head_pcw[XLEN-3:BTB_ADDRESS];
      btb_wr_target    = tgt_q[rd_ptr_q];
      btb_wr_valid     = 1'b1;
      btb_wr_is_ret    = ret_q[rd_ptr_q];
      btb_wr_is_branch = br_q[rd_ptr_q];
    end
  end

  // Slot selection: new entries go to the tail, req0 ahead of req1.
  always_comb begin
    logic [PW-1:0] pos;
    pos   = '0;
    new0  = acc0;
    new1  = acc1;
    slot0 = wr_ptr_q;
    slot1 = wr_ptr_q;
`ifdef BTB_UPD_COALESCE_EN
    // The head is skipped: it may be on the write port this very cycle.
    for (int k = 1; k < FIFO_DEPTH; k++) begin
      pos = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (acc0 && pcw_q[pos][BTB_ADDRESS-1:0] == req0_pcw[BTB_ADDRESS-1:0]) begin
          new0  = 1'b0;
          slot0 = pos;
        end
        if (acc1 && pcw_q[pos][BTB_ADDRESS-1:0] == req1_pcw[BTB_ADDRESS-1:0]) begin
          new1  = 1'b0;
          slot1 = pos;
        end
      end
    end
    if (new1) slot1 = wr_ptr_q + PW'(new0);
    if (new0 && new1 && req0_pcw[BTB_ADDRESS-1:0] == req1_pcw[BTB_ADDRESS-1:0]) begin
      new1  = 1'b0;
      slot1 = slot0;
    end
`else
    slot1 = wr_ptr_q + PW'(acc0);
`endif
    push_cnt = CW'(new0) + CW'(new1);
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q  <= INIT;
      widx_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        INIT, FLUSH: begin
          widx_q <= widx_q + 1'b1;
          if (widx_q == '1) state_q <= RUN;
        end
        RUN: begin
          if (flush_req) begin
            state_q  <= FLUSH;
            widx_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
          end else begin
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            wr_ptr_q <= wr_ptr_q + PW'(new0) + PW'(new1);
            count_q  <= count_q + push_cnt - CW'(pop);
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (acc0) begin
      pcw_q[slot0] <= req0_pcw;
      tgt_q[slot0] <= req0_target;
      ret_q[slot0] <= req0_is_ret;
      br_q[slot0]  <= req0_is_branch;
    end
    if (acc1) begin
      pcw_q[slot1] <= req1_pcw;
      tgt_q[slot1] <= req1_target;
      ret_q[slot1] <= req1_is_ret;
      br_q[slot1]  <= req1_is_branch;
    end
  end
endmodule
